// File: rtl/serial_out_pkg.sv
// Shared constants for the serial_out scheduler slice.
// Holds the FSM state encodings and the engine idle-mode codes.
package serial_out_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_ACK    = 3'd3;
    localparam logic [2:0] S_ABORT  = 3'd4;

    localparam logic [1:0] IM_LOW    = 2'b00;
    localparam logic [1:0] IM_HIGH   = 2'b01;
    localparam logic [1:0] IM_KEEP   = 2'b10;
    localparam logic [1:0] IM_REPEAT = 2'b11;

endpackage

// File: rtl/serial_out_tick_div.sv
// Bit-period tick divider: counts 0..div while enabled, pulses tick on wrap.
// Ports: clk, rst (async high), clear, en, div (period-1), tick (registered).
module serial_out_tick_div #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clear) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (en) begin
            if (cnt == div) begin
                cnt  <= '0;
                tick <= 1'b1;
            end else begin
                cnt  <= cnt + 1'b1;
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/serial_out_sched.sv
// Round-robin scheduler sharing one serial_out engine among NUM_REQ requesters.
// Ports: i_req/i_data/i_div/i_abort from requesters; o_grant/o_ack/o_abort_ack/
// o_busy back to them; o_so_* drive the engine, i_so_done_tick returns from it.
module serial_out_sched
    import serial_out_pkg::*;
#(
    parameter int         NUM_REQ   = 4,
    parameter int         DATA_BIT  = 16,
    parameter int         DIV_WIDTH = 16,
    parameter logic [1:0] IDLE_MODE = 2'b00
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ*DATA_BIT-1:0]   i_data,
    input  logic [NUM_REQ*DIV_WIDTH-1:0]  i_div,
    input  logic                          i_abort,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic [NUM_REQ-1:0]            o_ack,
    output logic                          o_abort_ack,
    output logic                          o_busy,
    output logic                          o_so_start,
    output logic                          o_so_stop,
    output logic                          o_so_tick,
    output logic [1:0]                    o_so_idle_mode,
    output logic [DATA_BIT-1:0]           o_so_data,
    input  logic                          i_so_done_tick
);

    localparam int IDX_W = $clog2(NUM_REQ);
    // REPEAT is not a legal engine mode here; fall back to LOW.
    localparam logic [1:0] MODE = (IDLE_MODE == IM_REPEAT) ? IM_LOW : IDLE_MODE;

    logic [2:0]           state;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     owner;
    logic [IDX_W-1:0]     win;
    logic [DIV_WIDTH-1:0] div_q;
    logic                 tick_en;

    // Search upward from ptr+1; iterate farthest-first so the nearest wins.
    always_comb begin
        int j;
        j   = 0;
        win = ptr;
        for (int i = NUM_REQ; i >= 1; i--) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ)
                j = j - NUM_REQ;
            if (i_req[j[IDX_W-1:0]])
                win = j[IDX_W-1:0];
        end
    end

    // Counter runs from LAUNCH on and stops the cycle S_RUN is left.
    assign tick_en = (state == S_LAUNCH) ||
                     (state == S_RUN && !i_so_done_tick && !i_abort);

    serial_out_tick_div #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_tick_div (
        .clk   (clk),
        .rst   (rst),
        .clear (!tick_en),
        .en    (tick_en),
        .div   (div_q),
        .tick  (o_so_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            ptr            <= IDX_W'(NUM_REQ - 1);
            owner          <= '0;
            div_q          <= '0;
            o_grant        <= '0;
            o_ack          <= '0;
            o_abort_ack    <= 1'b0;
            o_busy         <= 1'b0;
            o_so_start     <= 1'b0;
            o_so_stop      <= 1'b0;
            o_so_idle_mode <= MODE;
            o_so_data      <= '0;
        end else begin
            o_so_start     <= 1'b0;
            o_so_stop      <= 1'b0;
            o_ack          <= '0;
            o_abort_ack    <= 1'b0;
            o_so_idle_mode <= MODE;
            case (state)
                S_IDLE: begin
                    if (|i_req) begin
                        owner      <= win;
                        div_q      <= i_div[win*DIV_WIDTH +: DIV_WIDTH];
                        o_so_data  <= i_data[win*DATA_BIT +: DATA_BIT];
                        o_grant    <= NUM_REQ'(1) << win;
                        o_so_start <= 1'b1;
                        o_busy     <= 1'b1;
                        state      <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    state <= S_RUN;
                end
                S_RUN: begin
                    // done has priority over a same-cycle abort
                    if (i_so_done_tick) begin
                        o_ack <= o_grant;
                        ptr   <= owner;
                        state <= S_ACK;
                    end else if (i_abort) begin
                        o_so_stop   <= 1'b1;
                        o_abort_ack <= 1'b1;
                        ptr         <= owner;
                        state       <= S_ABORT;
                    end
                end
                S_ACK, S_ABORT: begin
                    o_grant <= '0;
                    o_busy  <= 1'b0;
                    state   <= S_IDLE;
                end
                default: begin
                    o_grant <= '0;
                    o_busy  <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_out_sched.sv
// Directed bench for serial_out_sched: table of transfers plus hand sequences.
// Acts as requesters and as a simple engine model raising done.
module tb_serial_out_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  i_req;
    logic [63:0] i_data;
    logic [63:0] i_div;
    logic        i_abort;
    logic [3:0]  o_grant;
    logic [3:0]  o_ack;
    logic        o_abort_ack;
    logic        o_busy;
    logic        o_so_start;
    logic        o_so_stop;
    logic        o_so_tick;
    logic [1:0]  o_so_idle_mode;
    logic [15:0] o_so_data;
    logic        i_so_done_tick;

    int checks   = 0;
    int failures = 0;

    localparam logic [63:0] DATA_ALL = {16'h0F0F, 16'hBEEF, 16'h1234, 16'hA5C3};

    serial_out_sched #(
        .NUM_REQ   (4),
        .DATA_BIT  (16),
        .DIV_WIDTH (16),
        .IDLE_MODE (2'b00)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_req          (i_req),
        .i_data         (i_data),
        .i_div          (i_div),
        .i_abort        (i_abort),
        .o_grant        (o_grant),
        .o_ack          (o_ack),
        .o_abort_ack    (o_abort_ack),
        .o_busy         (o_busy),
        .o_so_start     (o_so_start),
        .o_so_stop      (o_so_stop),
        .o_so_tick      (o_so_tick),
        .o_so_idle_mode (o_so_idle_mode),
        .o_so_data      (o_so_data),
        .i_so_done_tick (i_so_done_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] div;
        int          nticks;
        logic        drop;
        logic [3:0]  exp_grant;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_data(input logic [3:0] g);
        logic [15:0] d;
        case (g)
            4'b0001: d = 16'hA5C3;
            4'b0010: d = 16'h1234;
            4'b0100: d = 16'hBEEF;
            4'b1000: d = 16'h0F0F;
            default: d = 16'hXXXX;
        endcase
        return d;
    endfunction

    task automatic do_reset();
        rst            = 1'b1;
        i_req          = '0;
        i_data         = DATA_ALL;
        i_div          = '0;
        i_abort        = 1'b0;
        i_so_done_tick = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outs", {3'b0, o_grant, o_ack, o_abort_ack, o_busy,
            o_so_start, o_so_stop, o_so_tick, o_so_data}, 32'h0);
        chk("reset_idle_mode", {30'b0, o_so_idle_mode}, 32'h0);
        rst = 1'b0;
    endtask

    // Waits for the LAUNCH cycle; request must already be set before the edge.
    task automatic wait_grant(input logic [3:0] exp);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (o_grant == 4'b0 && n < 10);
        chk("grant", {28'b0, o_grant}, {28'b0, exp});
        chk("grant_latency", n, 1);
        chk("start", {31'b0, o_so_start}, 32'd1);
        chk("launch_no_tick", {31'b0, o_so_tick}, 32'd0);
        chk("data", {16'b0, o_so_data}, {16'b0, exp_data(exp)});
    endtask

    // Counts ticks in S_RUN; tick m is expected in RUN cycle m*(div+1).
    task automatic run_ticks(input logic [15:0] div, input int n, input int cyc0);
        int cyc, got, bad, lim;
        cyc = cyc0;
        got = 0;
        bad = 0;
        lim = n * (int'(div) + 1) + 8;
        while (got < n && cyc < lim) begin
            @(negedge clk);
            cyc++;
            if (o_so_tick) begin
                got++;
                if (cyc != got * (int'(div) + 1))
                    bad++;
            end
        end
        chk("tick_count", got, n);
        chk("tick_phase", bad, 0);
    endtask

    task automatic finish_xfer(input logic [3:0] exp, input logic with_abort);
        i_so_done_tick = 1'b1;
        i_abort        = with_abort;
        @(negedge clk);
        i_so_done_tick = 1'b0;
        i_abort        = 1'b0;
        chk("ack", {28'b0, o_ack}, {28'b0, exp});
        chk("ack_grant_held", {28'b0, o_grant}, {28'b0, exp});
        chk("ack_no_stop", {30'b0, o_so_stop, o_abort_ack}, 32'd0);
        chk("ack_no_tick", {31'b0, o_so_tick}, 32'd0);
        chk("ack_busy", {31'b0, o_busy}, 32'd1);
        chk("ack_data", {16'b0, o_so_data}, {16'b0, exp_data(exp)});
        @(negedge clk);
        chk("idle_busy", {31'b0, o_busy}, 32'd0);
        chk("idle_ack_clear", {28'b0, o_ack}, 32'd0);
        chk("idle_grant_clear", {28'b0, o_grant}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{4'b1011, 16'd0, 2,   1'b0, 4'b0001};
        vecs[1] = '{4'b1011, 16'd1, 2,   1'b0, 4'b0010};
        vecs[2] = '{4'b1011, 16'd3, 256, 1'b0, 4'b1000};
        vecs[3] = '{4'b1011, 16'd0, 3,   1'b0, 4'b0001};
        vecs[4] = '{4'b1011, 16'd2, 2,   1'b0, 4'b0010};
        vecs[5] = '{4'b1011, 16'd0, 1,   1'b0, 4'b1000};
        vecs[6] = '{4'b0100, 16'd4, 2,   1'b1, 4'b0100};
        vecs[7] = '{4'b1001, 16'd0, 2,   1'b0, 4'b1000};
        vecs[8] = '{4'b1001, 16'd1, 2,   1'b0, 4'b0001};
        vecs[9] = '{4'b0110, 16'd0, 2,   1'b0, 4'b0010};

        // single request, div 0
        do_reset();
        i_req = 4'b0001;
        wait_grant(4'b0001);
        run_ticks(16'd0, 4, 0);
        finish_xfer(4'b0001, 1'b0);

        // round-robin table from a fresh reset
        do_reset();
        for (int v = 0; v < 10; v++) begin
            i_req  = vecs[v].req;
            i_div  = {4{vecs[v].div}};
            i_data = DATA_ALL;
            wait_grant(vecs[v].exp_grant);
            if (vecs[v].drop) begin
                i_req  = 4'b0;
                i_div  = {4{16'd9}};
                i_data = ~DATA_ALL;
            end
            run_ticks(vecs[v].div, vecs[v].nticks, 0);
            finish_xfer(vecs[v].exp_grant, 1'b0);
        end

        // abort ignored in LAUNCH, then taken mid-RUN (ptr now 1)
        i_req  = 4'b1111;
        i_div  = {4{16'd1}};
        i_data = DATA_ALL;
        wait_grant(4'b0100);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        chk("launch_abort_ignored", {31'b0, o_abort_ack}, 32'd0);
        run_ticks(16'd1, 2, 1);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        chk("abort_stop", {31'b0, o_so_stop}, 32'd1);
        chk("abort_ack_pulse", {31'b0, o_abort_ack}, 32'd1);
        chk("abort_no_ack", {28'b0, o_ack}, 32'd0);
        chk("abort_no_tick", {31'b0, o_so_tick}, 32'd0);
        @(negedge clk);
        chk("abort_idle", {29'b0, o_busy, o_so_stop, o_abort_ack}, 32'd0);
        chk("abort_idle_tick", {31'b0, o_so_tick}, 32'd0);

        // next in rr order, then abort and done together
        wait_grant(4'b1000);
        run_ticks(16'd1, 2, 0);
        finish_xfer(4'b1000, 1'b1);

        // async reset mid-RUN with div 5
        i_div = {4{16'd5}};
        wait_grant(4'b0001);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst_outs", {3'b0, o_grant, o_ack, o_abort_ack, o_busy,
            o_so_start, o_so_stop, o_so_tick, o_so_data}, 32'h0);
        @(negedge clk);
        rst   = 1'b0;
        i_req = 4'b0110;
        i_div = {4{16'd0}};
        wait_grant(4'b0010);
        run_ticks(16'd0, 2, 0);
        finish_xfer(4'b0010, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_out_sched.md
Name: serial_out_sched

Overview:
- Round-robin scheduler that shares one serial_out engine among NUM_REQ requesters.
- Arbitrates requests and latches the winner's data word and bit-period divider.
- Drives the engine's start/stop/tick/idle_mode/data inputs and waits for its done tick.
- Acknowledges the winner on completion. Sits between requester logic and the single serial_out instance.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- DATA_BIT, 16: data word width; must match the engine.
- DIV_WIDTH, 16: width of the per-requester tick divider.
- IDLE_MODE, 2'b00: idle_mode driven to the engine. Legal values: 00 LOW, 01 HIGH, 10 KEEP. 11 REPEAT is illegal.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- i_req  in  NUM_REQ  level request per requester; held until o_ack or o_abort_ack
- i_data  in  NUM_REQ*DATA_BIT  flattened data words; requester r at [r*DATA_BIT +: DATA_BIT]
- i_div  in  NUM_REQ*DIV_WIDTH  flattened tick dividers; tick period = div+1 clocks
- i_abort  in  1  abort the current transfer
- o_grant  out  NUM_REQ  one-hot owner; held from LAUNCH through ACK/ABORT
- o_ack  out  NUM_REQ  one-cycle completion pulse to the owner
- o_abort_ack  out  1  one-cycle pulse when an abort is taken
- o_busy  out  1  high in any state other than S_IDLE
- o_so_start  out  1  engine start pulse
- o_so_stop  out  1  engine stop pulse
- o_so_tick  out  1  engine tick
- o_so_idle_mode  out  2  constant IDLE_MODE
- o_so_data  out  DATA_BIT  latched data word of the owner
- i_so_done_tick  in  1  engine completion pulse

Behaviour:
- All outputs are registered.
- Reset values: every output 0 except o_so_idle_mode = IDLE_MODE. State S_IDLE; rr pointer = NUM_REQ-1, so requester 0 has first priority; tick counter 0.
- Reset asserted mid-transfer aborts silently: no ack, no stop pulse. The engine's own reset is the integrator's concern.
- States:
  - S_IDLE: if i_req != 0, pick the first set bit searching upward (wrapping) from ptr+1. Latch its data and divider, go to S_LAUNCH. Otherwise stay.
  - S_LAUNCH (1 cycle): o_grant = winner, o_so_start = 1, o_so_data valid. Tick counter cleared. Go to S_RUN.
  - S_RUN:
    - Tick counter counts 0..div_latched; o_so_tick = 1 for one cycle when the counter wraps.
    - div = 0 gives a tick every cycle. Maximum period is 2^DIV_WIDTH clocks.
    - i_so_done_tick goes to S_ACK. i_abort goes to S_ABORT.
  - S_ACK (1 cycle): o_ack[owner] = 1, ptr = owner, o_grant cleared. Go to S_IDLE.
  - S_ABORT (1 cycle): o_so_stop = 1, o_abort_ack = 1, ptr = owner, o_grant cleared. Go to S_IDLE.
- Latency:
  - Request sampled in cycle 0 gives grant and start in cycle 1; ticks begin in cycle 2 at the earliest.
  - done in cycle k gives ack in cycle k+1 and S_IDLE in cycle k+2.
  - The next grant appears at k+3 at the earliest.
- Ticks are never generated outside S_RUN. The tick counter does not wrap past div_latched.
- Changes to i_data/i_div after S_IDLE latching are ignored until the next arbitration.
- Deasserting i_req during a transfer does not cancel it; the transfer completes and is acked.
- i_abort outside S_RUN is ignored. i_abort and i_so_done_tick in the same cycle: done wins, giving S_ACK and no stop pulse.
- A requester still holding i_req after its ack competes again, at lowest priority.
- Unknown state encoding recovers to S_IDLE.

Decomposition:
- Package serial_out_pkg holds:
  - state encodings S_IDLE/S_LAUNCH/S_RUN/S_ACK/S_ABORT (3 bits);
  - engine idle-mode constants LOW/HIGH/KEEP/REPEAT.
- Sub-module serial_out_tick_div: a clear/enable/div counter producing a one-cycle tick. The scheduler holds the arbiter and the FSM.

Test Plan:
- Single request, req=4'b0001, data=16'hA5C3, div=0 → grant 0001 and start one cycle later, ticks every cycle. Engine model done → o_ack=0001 one cycle after done; o_busy low two cycles after done.
- div=3 → o_so_tick high exactly one cycle in four, first tick at the 4th cycle of S_RUN. A tick count of 16*DATA_BIT is observed before done with TICK_PER_BIT=16.
- req=4'b1011 held continuously after reset → grant order 0,1,3,0,1,3. Each granted word equals the matching i_data slice.
- i_abort pulsed mid-S_RUN → one-cycle o_so_stop and o_abort_ack, no o_ack, ticks stop. The next requester in rr order is granted.
- i_abort and i_so_done_tick in the same cycle → o_ack asserted, o_so_stop stays 0.
- rst asserted during S_RUN with div=5 → all outputs 0 asynchronously. After release, req=4'b0110 is granted to requester 1 first.
